// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage: FSM encoding, PC increment,
// default reset PC and the word-alignment helper.
package fetch_unit_pkg;

  typedef enum logic {
    ST_RUN        = 1'b0,
    ST_HOLD_REDIR = 1'b1
  } fetch_state_e;

  localparam logic [31:0] PC_INC           = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Instructions are word aligned: clear the two byte-offset bits.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// Next-PC selection: sequential PC+4, branch/jump redirect target (branch wins)
// or the redirect parked while the front end was stalled.
module fetch_next_pc
  import fetch_unit_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic [31:0] pend_i,
  input  logic        hold_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  input  logic        jump_i,
  input  logic [31:0] jump_target_i,
  output logic        redir_req_o,
  output logic [31:0] redir_target_o,
  output logic        apply_redir_o,
  output logic [31:0] next_pc_o
);

  // Select the redirect target and the PC to load when the stage is not stalled.
  always_comb begin
    redir_req_o    = branch_taken_i | jump_i;
    redir_target_o = align_word(branch_taken_i ? branch_target_i : jump_target_i);
    apply_redir_o  = hold_i | redir_req_o;
    if (hold_i) begin
      next_pc_o = align_word(pend_i);
    end else if (redir_req_o) begin
      next_pc_o = redir_target_o;
    end else begin
      next_pc_o = pc_i + PC_INC;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, redirect-while-stalled FSM and an
// optional fetched-instruction counter enabled by macro FETCH_PERF_CNT_EN.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  input  logic        jump_i,
  input  logic [31:0] jump_target_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        stall_o,
  output logic        flush_o,
  output logic [31:0] fetch_cnt_o
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  pend_q, pend_d;
  logic         redir_req;
  logic [31:0]  redir_target;
  logic         apply_redir;
  logic [31:0]  next_pc;

  fetch_next_pc u_next_pc (
    .pc_i            (pc_q),
    .pend_i          (pend_q),
    .hold_i          (state_q == ST_HOLD_REDIR),
    .branch_taken_i  (branch_taken_i),
    .branch_target_i (branch_target_i),
    .jump_i          (jump_i),
    .jump_target_i   (jump_target_i),
    .redir_req_o     (redir_req),
    .redir_target_o  (redir_target),
    .apply_redir_o   (apply_redir),
    .next_pc_o       (next_pc)
  );

  assign imem_addr_o = pc_q;
  assign pc_o        = pc_q;
  assign inst_o      = imem_rdata_i;
  assign stall_o     = stall_i;

  // Next state: advance/redirect when not stalled, park a redirect seen under stall.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    flush_o = 1'b0;
    if (!stall_i) begin
      pc_d    = next_pc;
      flush_o = apply_redir;
      state_d = ST_RUN;
    end else if (state_q == ST_RUN && redir_req) begin
      pend_d  = redir_target;
      state_d = ST_HOLD_REDIR;
    end
  end

  // State, PC and pending-target registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] cnt_q, cnt_d;

  // Count every cycle the PC moves, saturating at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (!stall_i && cnt_q != 32'hFFFF_FFFF) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign fetch_cnt_o = cnt_q;
`else
  assign fetch_cnt_o = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit.
module tb_fetch_unit;

`ifdef FETCH_PERF_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic        clk_i;
  logic        rst_i;
  logic        stall_i;
  logic        branch_taken_i;
  logic [31:0] branch_target_i;
  logic        jump_i;
  logic [31:0] jump_target_i;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_rdata_i;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        stall_o;
  logic        flush_o;
  logic [31:0] fetch_cnt_o;

  int errors = 0;
  int checks = 0;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .stall_i         (stall_i),
    .branch_taken_i  (branch_taken_i),
    .branch_target_i (branch_target_i),
    .jump_i          (jump_i),
    .jump_target_i   (jump_target_i),
    .imem_addr_o     (imem_addr_o),
    .imem_rdata_i    (imem_rdata_i),
    .pc_o            (pc_o),
    .inst_o          (inst_o),
    .stall_o         (stall_o),
    .flush_o         (flush_o),
    .fetch_cnt_o     (fetch_cnt_o)
  );

  // Simple instruction memory: data is a fixed scramble of the address.
  assign imem_rdata_i = imem_addr_o ^ 32'hA5A5_0F0F;

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_redir();
    branch_taken_i  = 1'b0;
    branch_target_i = 32'h0;
    jump_i          = 1'b0;
    jump_target_i   = 32'h0;
  endtask

  task automatic test_reset();
    rst_i   = 1'b0;
    stall_i = 1'b0;
    clear_redir();
    #2;
    tick();
    tick();
    checks++;
    if (pc_o !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want %h", pc_o, 32'h0); end
    checks++;
    if (imem_addr_o !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want %h", imem_addr_o, 32'h0); end
    checks++;
    if (flush_o !== 1'b0) begin errors++; $display("FAIL reset_flush: got %b want 0", flush_o); end
    checks++;
    if (fetch_cnt_o !== 32'h0) begin errors++; $display("FAIL reset_cnt: got %h want 0", fetch_cnt_o); end
    stall_i = 1'b1;
    #1;
    checks++;
    if (stall_o !== 1'b1) begin errors++; $display("FAIL reset_stall_o: got %b want 1", stall_o); end
    stall_i = 1'b0;
    #1;
    checks++;
    if (stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall_o0: got %b want 0", stall_o); end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc;
    exp_pc = 32'h0;
    rst_i = 1'b1;
    #1;
    checks++;
    if (pc_o !== exp_pc) begin errors++; $display("FAIL seq_pc_start: got %h want %h", pc_o, exp_pc); end
    for (int i = 0; i < 4; i++) begin
      tick();
      exp_pc = exp_pc + 32'd4;
      checks++;
      if (pc_o !== exp_pc) begin errors++; $display("FAIL seq_pc%0d: got %h want %h", i, pc_o, exp_pc); end
      checks++;
      if (inst_o !== (exp_pc ^ 32'hA5A5_0F0F)) begin
        errors++; $display("FAIL seq_inst%0d: got %h want %h", i, inst_o, exp_pc ^ 32'hA5A5_0F0F);
      end
      checks++;
      if (flush_o !== 1'b0) begin errors++; $display("FAIL seq_flush%0d: got %b want 0", i, flush_o); end
    end
    checks++;
    if (fetch_cnt_o !== (CNT_ON ? 32'd4 : 32'd0)) begin
      errors++; $display("FAIL seq_cnt: got %h want %h", fetch_cnt_o, CNT_ON ? 32'd4 : 32'd0);
    end
  endtask

  task automatic test_branch();
    // From 0x10 advance four more fetches to 0x20.
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (pc_o !== 32'h20) begin errors++; $display("FAIL br_pre_pc: got %h want 20", pc_o); end
    branch_taken_i  = 1'b1;
    branch_target_i = 32'h103;
    #1;
    checks++;
    if (flush_o !== 1'b1) begin errors++; $display("FAIL br_flush: got %b want 1", flush_o); end
    tick();
    clear_redir();
    checks++;
    if (pc_o !== 32'h100) begin errors++; $display("FAIL br_pc: got %h want 100", pc_o); end
    #1;
    checks++;
    if (flush_o !== 1'b0) begin errors++; $display("FAIL br_flush_after: got %b want 0", flush_o); end
  endtask

  task automatic test_priority();
    branch_taken_i  = 1'b1;
    branch_target_i = 32'h200;
    jump_i          = 1'b1;
    jump_target_i   = 32'h300;
    #1;
    checks++;
    if (flush_o !== 1'b1) begin errors++; $display("FAIL prio_flush: got %b want 1", flush_o); end
    tick();
    clear_redir();
    checks++;
    if (pc_o !== 32'h200) begin errors++; $display("FAIL prio_pc: got %h want 200", pc_o); end
    jump_i        = 1'b1;
    jump_target_i = 32'h301;
    tick();
    clear_redir();
    checks++;
    if (pc_o !== 32'h300) begin errors++; $display("FAIL jump_pc: got %h want 300", pc_o); end
  endtask

  task automatic test_stall_redirect();
    jump_i        = 1'b1;
    jump_target_i = 32'h40;
    tick();
    clear_redir();
    checks++;
    if (pc_o !== 32'h40) begin errors++; $display("FAIL st_pre_pc: got %h want 40", pc_o); end
    stall_i       = 1'b1;
    jump_i        = 1'b1;
    jump_target_i = 32'h80;
    #1;
    checks++;
    if (flush_o !== 1'b0) begin errors++; $display("FAIL st_flush0: got %b want 0", flush_o); end
    checks++;
    if (stall_o !== 1'b1) begin errors++; $display("FAIL st_stall_o: got %b want 1", stall_o); end
    tick();
    clear_redir();
    branch_taken_i  = 1'b1;
    branch_target_i = 32'h90;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (pc_o !== 32'h40 || flush_o !== 1'b0) begin
        errors++; $display("FAIL st_hold%0d: got pc=%h flush=%b want pc=40 flush=0", i, pc_o, flush_o);
      end
      tick();
    end
    clear_redir();
    checks++;
    if (pc_o !== 32'h40) begin errors++; $display("FAIL st_hold_end: got %h want 40", pc_o); end
    stall_i = 1'b0;
    #1;
    checks++;
    if (flush_o !== 1'b1) begin errors++; $display("FAIL st_release_flush: got %b want 1", flush_o); end
    tick();
    checks++;
    if (pc_o !== 32'h80) begin errors++; $display("FAIL st_release_pc: got %h want 80", pc_o); end
    #1;
    checks++;
    if (flush_o !== 1'b0) begin errors++; $display("FAIL st_post_flush: got %b want 0", flush_o); end
    tick();
    checks++;
    if (pc_o !== 32'h84) begin errors++; $display("FAIL st_post_pc: got %h want 84", pc_o); end
  endtask

  task automatic test_reset_in_hold();
    stall_i       = 1'b1;
    jump_i        = 1'b1;
    jump_target_i = 32'h500;
    tick();
    clear_redir();
    #2;
    rst_i = 1'b0;
    #1;
    checks++;
    if (pc_o !== 32'h0) begin errors++; $display("FAIL rh_pc: got %h want 0", pc_o); end
    checks++;
    if (fetch_cnt_o !== 32'h0) begin errors++; $display("FAIL rh_cnt: got %h want 0", fetch_cnt_o); end
    tick();
    rst_i   = 1'b1;
    stall_i = 1'b0;
    #1;
    checks++;
    if (flush_o !== 1'b0 || pc_o !== 32'h0) begin
      errors++; $display("FAIL rh_release: got pc=%h flush=%b want pc=0 flush=0", pc_o, flush_o);
    end
    tick();
    checks++;
    if (pc_o !== 32'h4) begin errors++; $display("FAIL rh_next_pc: got %h want 4", pc_o); end
  endtask

  task automatic test_wrap();
    jump_i        = 1'b1;
    jump_target_i = 32'hFFFF_FFFF;
    tick();
    clear_redir();
    checks++;
    if (pc_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pre_pc: got %h want fffffffc", pc_o); end
`ifdef FETCH_PERF_CNT_EN
    force dut.cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.cnt_q;
`endif
    tick();
    checks++;
    if (pc_o !== 32'h0) begin errors++; $display("FAIL wrap_pc: got %h want 0", pc_o); end
    checks++;
    if (fetch_cnt_o !== (CNT_ON ? 32'hFFFF_FFFF : 32'h0)) begin
      errors++; $display("FAIL wrap_cnt: got %h want %h", fetch_cnt_o, CNT_ON ? 32'hFFFF_FFFF : 32'h0);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_priority();
    test_stall_redirect();
    test_reset_in_hold();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
